// File: rtl/bk_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bk_pkg;

  // Per-stage control payload carried alongside the g/p vectors.
  typedef struct packed {
    logic vld;
    logic c0;
    logic a_msb;
    logic b_msb;
  } bk_ctl_t;

  // Prefix operator (g_hi,p_hi) o (g_lo,p_lo); returns {g, p}.
  function automatic logic [1:0] bk_op(input logic g_hi, input logic p_hi,
                                       input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  // Ceiling log2 for elaboration-time sizing of the prefix tree.
  function automatic int bk_log2(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Two-input black prefix cell combining a high and a low (g,p) group.
// Latency: combinational.
// Backpressure: none.
module bk_prefix_cell
  import bk_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_o,
  output logic p_o
);

  assign {g_o, p_o} = bk_op(g_hi, p_hi, g_lo, p_lo);

endmodule

// File: rtl/bk_adder_pipe.sv
// WIDTH-bit Brent-Kung adder/subtractor with carry, overflow and zero flags.
// Latency: 3 cycles from input accept to out_valid, one result per cycle.
// Backpressure: single global advance; all stages stall while output is held.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LOG2W = bk_log2(WIDTH);
  // Up-sweep levels plus down-sweep levels.
  localparam int NLVL  = 2 * LOG2W - 1;

  // Stage registers
  logic [WIDTH-1:0] r_s1_g, r_s1_p;
  bk_ctl_t          r_s1_ctl;
  logic             r_s2_vld, r_s2_a_msb, r_s2_b_msb;
  logic [WIDTH:0]   r_s2_c;
  logic [WIDTH-1:0] r_s2_p;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_zero;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [1:0]       w_fold;
  logic [WIDTH-1:0] w_g_lvl [0:NLVL];
  logic [WIDTH-1:0] w_p_lvl [0:NLVL];
  logic [WIDTH-1:0] w_sum;

  // Whole pipe moves together; no bubble squeezing, so ready depends only on the output side.
  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;

  assign w_b_eff = op_sub ? ~b : b;
  assign w_c0    = op_sub | cin;

  // Stage 1: bitwise generate/propagate and the control bits needed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_g   <= '0;
      r_s1_p   <= '0;
      r_s1_ctl <= '0;
    end else if (w_adv) begin
      r_s1_ctl.vld <= in_valid;
      if (in_valid) begin
        r_s1_g         <= a & w_b_eff;
        r_s1_p         <= a ^ w_b_eff;
        r_s1_ctl.c0    <= w_c0;
        r_s1_ctl.a_msb <= a[WIDTH-1];
        r_s1_ctl.b_msb <= w_b_eff[WIDTH-1];
      end
    end
  end

  // Carry-in treated as a generate at position -1 and folded into bit 0; bit 0's
  // group propagate then becomes 0, so every tree output g is a true carry.
  assign w_fold     = bk_op(r_s1_g[0], r_s1_p[0], r_s1_ctl.c0, 1'b0);
  assign w_g_lvl[0] = {r_s1_g[WIDTH-1:1], w_fold[1]};
  assign w_p_lvl[0] = {r_s1_p[WIDTH-1:1], w_fold[0]};

  // Brent-Kung tree: levels below LOG2W are the up-sweep, the rest the down-sweep.
  for (genvar lv = 0; lv < NLVL; lv++) begin : g_lvl
    localparam int DIST = (lv < LOG2W) ? (1 << lv) : (1 << (NLVL - 1 - lv));
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit ACT = (lv < LOG2W) ?
                           (((i + 1) % (2 * DIST)) == 0) :
                           ((((i + 1) % (2 * DIST)) == DIST) && ((i + 1) >= 3 * DIST));
      if (ACT) begin : g_cell
        bk_prefix_cell u_cell (
          .g_hi (w_g_lvl[lv][i]),
          .p_hi (w_p_lvl[lv][i]),
          .g_lo (w_g_lvl[lv][i-DIST]),
          .p_lo (w_p_lvl[lv][i-DIST]),
          .g_o  (w_g_lvl[lv+1][i]),
          .p_o  (w_p_lvl[lv+1][i])
        );
      end else begin : g_pass
        assign w_g_lvl[lv+1][i] = w_g_lvl[lv][i];
        assign w_p_lvl[lv+1][i] = w_p_lvl[lv][i];
      end
    end
  end

  // Stage 2: register the carries into every bit position plus carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld   <= 1'b0;
      r_s2_c     <= '0;
      r_s2_p     <= '0;
      r_s2_a_msb <= 1'b0;
      r_s2_b_msb <= 1'b0;
    end else if (w_adv) begin
      r_s2_vld <= r_s1_ctl.vld;
      if (r_s1_ctl.vld) begin
        r_s2_c     <= {w_g_lvl[NLVL], r_s1_ctl.c0};
        r_s2_p     <= r_s1_p;
        r_s2_a_msb <= r_s1_ctl.a_msb;
        r_s2_b_msb <= r_s1_ctl.b_msb;
      end
    end
  end

  assign w_sum = r_s2_p ^ r_s2_c[WIDTH-1:0];

  // Stage 3: final sum and flags; data only changes when a valid item lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_sum  <= w_sum;
        r_cout <= r_s2_c[WIDTH];
        r_ovf  <= (r_s2_a_msb == r_s2_b_msb) && (w_sum[WIDTH-1] != r_s2_a_msb);
        r_zero <= (w_sum == '0);
      end
    end
  end

  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
